iter_divider: RTL and testbench

//  Parametrised multi-cycle restoring divider. Successor to the single-cycle stream divider.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 23 ++
 rtl/iter_divider.sv | 138 +++++++++++++
 tb/tb_iter_divider.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and the signed
// magnitude helper used when latching operands.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Callers sign-extend into ABS_W bits and truncate the result back to WIDTH;
    // this keeps a single helper usable for any WIDTH up to ABS_W.
    localparam int ABS_W = 64;

    function automatic logic [ABS_W-1:0] abs_val(input logic [ABS_W-1:0] x);
        return x[ABS_W-1] ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference unless it borrowed.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {2'b00, divisor};
        q_bit   = ~diff[WIDTH+1];
        rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider with optional signed mode and ready/valid
// handshakes; one operation in flight, BITS_PER_CYCLE quotient bits per edge.
module iter_divider
    import div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter bit SIGNED_EN      = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_payload_dividend,
    input  logic [WIDTH-1:0] i_payload_divisor,
    input  logic             i_payload_signed,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_payload_quotient,
    output logic [WIDTH-1:0] o_payload_remainder,
    output logic             o_payload_div_by_zero
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] dvd_r, dvs_r;
    logic             neg_q, neg_r;

    logic             accept, last, sgn;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign accept = i_valid && i_ready;
    assign last   = (state == S_CALC) && (cnt == CW'(N - 1));
    assign sgn    = SIGNED_EN && i_payload_signed;

    always_comb begin
        mag_a = i_payload_dividend;
        mag_b = i_payload_divisor;
        if (sgn) begin
            mag_a = WIDTH'(abs_val(ABS_W'(signed'(i_payload_dividend))));
            mag_b = WIDTH'(abs_val(ABS_W'(signed'(i_payload_divisor))));
        end
    end

    // Step chain: stage 0 consumes the current MSB of the dividend shift register.
    logic [WIDTH:0]          rem_c [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] qbits;
    logic [WIDTH-1:0]        dvd_nxt;
    logic [WIDTH-1:0]        rem_fin;

    assign rem_c[0] = rem_r;

    for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem_in  (rem_c[j]),
            .bit_in  (dvd_r[WIDTH-1-j]),
            .divisor (dvs_r),
            .rem_out (rem_c[j+1]),
            .q_bit   (qbits[BITS_PER_CYCLE-1-j])
        );
    end

    // Quotient bits shift into the LSBs as dividend bits leave the MSBs.
    assign dvd_nxt = (dvd_r << BITS_PER_CYCLE) | WIDTH'(qbits);
    assign rem_fin = rem_c[BITS_PER_CYCLE][WIDTH-1:0];

    always_comb begin
        state_nxt = state;
        i_ready   = 1'b0;
        o_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                i_ready = 1'b1;
                if (i_valid)
                    state_nxt = (i_payload_divisor == '0) ? S_DONE : S_CALC;
            end
            S_CALC: if (last) state_nxt = S_DONE;
            S_DONE: begin
                o_valid = 1'b1;
                if (o_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt                   <= '0;
            rem_r                 <= '0;
            dvd_r                 <= '0;
            dvs_r                 <= '0;
            neg_q                 <= 1'b0;
            neg_r                 <= 1'b0;
            o_payload_quotient    <= '0;
            o_payload_remainder   <= '0;
            o_payload_div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    cnt   <= '0;
                    rem_r <= '0;
                    if (i_payload_divisor == '0) begin
                        o_payload_quotient    <= '1;
                        o_payload_remainder   <= '1;
                        o_payload_div_by_zero <= 1'b1;
                    end else begin
                        dvd_r                 <= mag_a;
                        dvs_r                 <= mag_b;
                        neg_q                 <= sgn && (i_payload_dividend[WIDTH-1] ^ i_payload_divisor[WIDTH-1]);
                        neg_r                 <= sgn && i_payload_dividend[WIDTH-1];
                        o_payload_div_by_zero <= 1'b0;
                    end
                end
                S_CALC: begin
                    rem_r <= rem_c[BITS_PER_CYCLE];
                    dvd_r <= dvd_nxt;
                    cnt   <= cnt + CW'(1);
                    // Sign fix-up folds into the last step so DONE follows immediately.
                    if (last) begin
                        o_payload_quotient  <= neg_q ? -dvd_nxt : dvd_nxt;
                        o_payload_remainder <= neg_r ? -rem_fin : rem_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: a BPC=1 signed-capable instance and a BPC=4
// unsigned-only instance, checked against plain-arithmetic expectations.
module tb_iter_divider;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         iv [2], ir [2], ov [2], ordy [2], sg [2], dz [2];
    logic [W-1:0] dd [2], ds [2], q [2], r [2];

    int total = 0;
    int bad   = 0;

    iter_divider #(.WIDTH(W), .BITS_PER_CYCLE(1), .SIGNED_EN(1'b1)) dut0 (
        .clk(clk), .reset(reset),
        .i_valid(iv[0]), .i_ready(ir[0]),
        .i_payload_dividend(dd[0]), .i_payload_divisor(ds[0]), .i_payload_signed(sg[0]),
        .o_valid(ov[0]), .o_ready(ordy[0]),
        .o_payload_quotient(q[0]), .o_payload_remainder(r[0]), .o_payload_div_by_zero(dz[0])
    );

    iter_divider #(.WIDTH(W), .BITS_PER_CYCLE(4), .SIGNED_EN(1'b0)) dut1 (
        .clk(clk), .reset(reset),
        .i_valid(iv[1]), .i_ready(ir[1]),
        .i_payload_dividend(dd[1]), .i_payload_divisor(ds[1]), .i_payload_signed(sg[1]),
        .o_valid(ov[1]), .o_ready(ordy[1]),
        .o_payload_quotient(q[1]), .o_payload_remainder(r[1]), .o_payload_div_by_zero(dz[1])
    );

    function automatic int nsteps(input int s);
        return (s == 0) ? 32 : 8;
    endfunction

    // {quotient, remainder, div_by_zero} from the arithmetic definition.
    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, qq, rr;
        if (b == 32'd0) return {32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        qq = sa / sb;
        rr = sa % sb;
        return {qq[31:0], rr[31:0], 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input int s, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input int hold);
        logic [64:0] e;
        int lat, t;
        e = model(a, b, sgn && (s == 0));
        @(negedge clk);
        dd[s] = a; ds[s] = b; sg[s] = sgn; iv[s] = 1'b1; ordy[s] = 1'b0;
        t = 0;
        while (!ir[s] && t < 100) begin @(negedge clk); t++; end
        chk("accept_ready", {95'd0, ir[s]}, 96'd1);
        @(posedge clk);
        #1 iv[s] = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!ov[s] && lat < 200) begin @(negedge clk); lat++; end
        chk("latency", 96'(lat), 96'((b == 32'd0) ? 0 : nsteps(s)));
        chk("result", {31'd0, q[s], r[s], dz[s]}, {31'd0, e});
        chk("busy_iready", {95'd0, ir[s]}, 96'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold", {29'd0, ov[s], ir[s], q[s], r[s], dz[s]}, {29'd0, 1'b1, 1'b0, e});
        end
        ordy[s] = 1'b1;
        @(posedge clk);
        #1 ordy[s] = 1'b0;
        chk("release", {94'd0, ov[s], ir[s]}, 96'b01);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            iv[s] = 1'b0; ordy[s] = 1'b0; sg[s] = 1'b0; dd[s] = '0; ds[s] = '0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++)
            chk("reset_state", {29'd0, ov[s], ir[s], q[s], r[s], dz[s]}, {29'd0, 1'b0, 1'b1, 65'd0});
        reset = 1'b0;

        run_op(0, 32'd17,         32'd5,          1'b0, 0);
        run_op(0, 32'h1234_5678,  32'd0,          1'b0, 0);
        run_op(0, -32'sd17,       32'd5,          1'b1, 0);
        run_op(0, 32'd17,         -32'sd5,        1'b1, 0);
        run_op(0, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 0);
        run_op(0, 32'hFFFF_FFFF,  32'd1,          1'b0, 0);
        run_op(0, 32'd3,          32'd9,          1'b0, 0);
        run_op(0, 32'd1000,       32'd7,          1'b0, 10);

        // Abort mid-calculation: reset lands at the 10th step edge.
        @(negedge clk);
        dd[0] = 32'd12345; ds[0] = 32'd11; sg[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort", {29'd0, ov[0], ir[0], q[0], r[0], dz[0]}, {29'd0, 1'b0, 1'b1, 65'd0});

        run_op(1, 32'd100,       32'd7, 1'b0, 0);
        run_op(1, -32'sd17,      32'd5, 1'b1, 0);
        run_op(1, 32'hDEAD_BEEF, 32'd0, 1'b0, 2);

        for (int n = 0; n < 24; n++) begin
            int s;
            logic [31:0] a, b;
            s = (n < 16) ? 0 : 1;
            a = $urandom();
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                default: b = $urandom();
            endcase
            run_op(s, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
